// File: rtl/ps2_dir_decoder_pkg.sv
// Shared constants for the PS/2 direction decoder: set-2 scancodes, the
// direction encoding used by the snake control FSM, and FSM state types.
package ps2_dir_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_e;
    typedef enum logic [1:0] {DEC_IDLE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] dir;
    } key_t;

    function automatic key_t arrow_key(input logic [7:0] code);
        key_t k;
        k = '0;
        case (code)
            SC_LEFT:  k = '{1'b1, DIR_LEFT};
            SC_RIGHT: k = '{1'b1, DIR_RIGHT};
            SC_UP:    k = '{1'b1, DIR_UP};
            SC_DOWN:  k = '{1'b1, DIR_DOWN};
            default:  k = '0;
        endcase
        return k;
    endfunction

    function automatic key_t wasd_key(input logic [7:0] code);
        key_t k;
        k = '0;
        case (code)
            SC_A:    k = '{1'b1, DIR_LEFT};
            SC_D:    k = '{1'b1, DIR_RIGHT};
            SC_W:    k = '{1'b1, DIR_UP};
            SC_S:    k = '{1'b1, DIR_DOWN};
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_dir_decoder_if.sv
// Decoder-to-consumer bundle: direction, held keys, raw byte stream and debug states.
interface ps2_dir_decoder_if;
    import ps2_dir_decoder_pkg::*;

    // dir_valid, rx_valid and frame_err are single-cycle strobes with no
    // ready/backpressure: the consumer must take them on the cycle they are high.
    logic [1:0]   dir;
    logic         dir_valid;
    logic [3:0]   held;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         frame_err;
    frame_state_e frame_state;
    dec_state_e   dec_state;

    modport master (output dir, dir_valid, held, rx_byte, rx_valid, frame_err,
                    frame_state, dec_state);
    modport slave  (input  dir, dir_valid, held, rx_byte, rx_valid, frame_err,
                    frame_state, dec_state);
endinterface

// File: rtl/ps2_dir_decoder_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronisers, ps2_clk glitch filter,
// start/data/parity/stop FSM and an inter-edge timeout.
module ps2_dir_decoder_rx_frame
    import ps2_dir_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_dat,
    output logic [7:0]   rx_byte,
    output logic         rx_valid,
    output logic         frame_err,
    output frame_state_e state
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]   clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic         filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_ok_q, par_ok_d;
    logic [7:0]   rx_byte_q, rx_byte_d;
    logic         rx_valid_q, rx_valid_d;
    logic         frame_err_q, frame_err_d;
    logic         fall, dat_s;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        dat_s      = dat_sync_q[1];
        filt_d     = filt_q;
        filt_cnt_d = '0;
        // The filtered level only flips after FILTER_CYCLES consecutive disagreeing samples.
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) filt_d = clk_sync_q[1];
            else                                      filt_cnt_d = filt_cnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        if (fall) begin
            tmo_cnt_d = '0;
            case (state_q)
                FR_IDLE: begin
                    if (!dat_s) begin
                        state_d   = FR_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                FR_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = FR_PARITY;
                end
                FR_PARITY: begin
                    par_ok_d = ^{dat_s, shift_q};
                    state_d  = FR_STOP;
                end
                FR_STOP: begin
                    state_d = FR_IDLE;
                    if (dat_s && par_ok_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = FR_IDLE;
            endcase
        end else if (state_q != FR_IDLE) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err_d = 1'b1;
                state_d     = FR_IDLE;
                tmo_cnt_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            state_q     <= FR_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign state     = state_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard direction decoder: turns E0-prefixed arrow make/break codes into
// a direction code and held-key flags. Define PS2_WASD_EN to also accept WASD.
module ps2_dir_decoder
    import ps2_dir_decoder_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    ps2_dir_decoder_if.master bus
);

    logic [7:0]   rx_byte;
    logic         rx_valid, frame_err;
    frame_state_e frame_state;

    ps2_dir_decoder_rx_frame #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .state    (frame_state)
    );

    dec_state_e dec_state_q, dec_state_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_valid_q, dir_valid_d;
    logic [3:0] held_q, held_d;
    logic       is_ext, is_brk;
    key_t       key;

    always_comb begin
        dec_state_d = dec_state_q;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;
        held_d      = held_q;
        is_ext      = (dec_state_q == DEC_EXT) || (dec_state_q == DEC_EXT_BRK);
        is_brk      = (dec_state_q == DEC_BRK) || (dec_state_q == DEC_EXT_BRK);
        key         = '0;
        if (is_ext) key = arrow_key(rx_byte);
`ifdef PS2_WASD_EN
        if (!is_ext) key = wasd_key(rx_byte);
`endif
        // A framing error means any pending prefix may belong to a lost byte.
        if (frame_err) begin
            dec_state_d = DEC_IDLE;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                dec_state_d = is_brk ? DEC_EXT_BRK : DEC_EXT;
            end else if (rx_byte == SC_BRK) begin
                dec_state_d = is_ext ? DEC_EXT_BRK : DEC_BRK;
            end else begin
                dec_state_d = DEC_IDLE;
                if (key.hit) begin
                    if (is_brk) begin
                        held_d[key.dir] = 1'b0;
                    end else begin
                        held_d[key.dir] = 1'b1;
                        dir_d           = key.dir;
                        dir_valid_d     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_state_q <= DEC_IDLE;
            dir_q       <= DIR_RIGHT;
            dir_valid_q <= 1'b0;
            held_q      <= '0;
        end else begin
            dec_state_q <= dec_state_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            held_q      <= held_d;
        end
    end

    assign bus.dir         = dir_q;
    assign bus.dir_valid   = dir_valid_q;
    assign bus.held        = held_q;
    assign bus.rx_byte     = rx_byte;
    assign bus.rx_valid    = rx_valid;
    assign bus.frame_err   = frame_err;
    assign bus.frame_state = frame_state;
    assign bus.dec_state   = dec_state_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Self-checking bench for ps2_dir_decoder: directed PS/2 scenarios plus random
// byte streams compared against a scancode-level model of keyboard state.
module tb_ps2_dir_decoder;
    import ps2_dir_decoder_pkg::*;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 500;
    localparam int HP      = 30;

    logic clk, reset, ps2_clk, ps2_dat;
    ps2_dir_decoder_if bus ();

    ps2_dir_decoder #(
        .FILTER_CYCLES (FILTER),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] arrow_codes [4];
    logic [7:0] wasd_codes  [4];
    bit         m_ext, m_brk;
    logic [1:0] m_dir;
    logic [3:0] m_held;
    int         m_dv;

    initial begin
        arrow_codes = '{8'h6B, 8'h74, 8'h75, 8'h72};
        wasd_codes  = '{8'h1C, 8'h23, 8'h1D, 8'h1B};
    end

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_dir = 2'd1; m_held = 4'b0000;
    endtask

    task automatic model_rx(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            idx = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_ext && b == arrow_codes[i]) idx = i;
`ifdef PS2_WASD_EN
                if (!m_ext && b == wasd_codes[i]) idx = i;
`endif
            end
            if (idx >= 0) begin
                if (m_brk) m_held[idx] = 1'b0;
                else begin
                    m_held[idx] = 1'b1;
                    m_dir = 2'(idx);
                    m_dv++;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_err();
        m_ext = 0; m_brk = 0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    int rx_cnt = 0, dv_cnt = 0, fe_cnt = 0;
    bit rx_prev = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got byte %02h, none expected", bus.rx_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.rx_byte !== e) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h expected %02h", bus.rx_byte, e);
                    end
                end
            end
            if (bus.dir_valid) begin
                dv_cnt++;
                checks++;
                if (!rx_prev) begin
                    errors++;
                    $display("FAIL dir_valid_latency: pulse without rx_valid on previous cycle");
                end
            end
            if (bus.frame_err) fe_cnt++;
        end
        rx_prev = bus.rx_valid && !reset;
    end

    // ---------------- driver tasks ----------------
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            repeat (HP) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (HP) @(posedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(f, 11);
        ps2_dat = 1'b1;
        repeat (2 * HP) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        model_rx(b);
        send_frame(b, 1'b0);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        checks++;
        if (bus.dir !== m_dir) begin
            errors++;
            $display("FAIL %s_dir: got %0d expected %0d", tag, bus.dir, m_dir);
        end
        checks++;
        if (bus.held !== m_held) begin
            errors++;
            $display("FAIL %s_held: got %b expected %b", tag, bus.held, m_held);
        end
        checks++;
        if (dv_cnt !== m_dv) begin
            errors++;
            $display("FAIL %s_dir_valid_count: got %0d expected %0d", tag, dv_cnt, m_dv);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (5) @(posedge clk);
        reset = 1'b0;
        model_reset();
        m_dv = 0;
        @(negedge clk);
        checks++;
        if (bus.dir !== 2'd1 || bus.held !== 4'b0 || bus.rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: dir=%0d held=%b rx_byte=%02h expected 1/0000/00",
                     bus.dir, bus.held, bus.rx_byte);
        end
        checks++;
        if (bus.frame_state !== FR_IDLE || bus.dec_state !== DEC_IDLE) begin
            errors++;
            $display("FAIL reset_states: frame=%0d dec=%0d expected 0/0", bus.frame_state, bus.dec_state);
        end
        repeat (3000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_cnt + dv_cnt + fe_cnt != 0) begin
            errors++;
            $display("FAIL reset_idle_pulses: rx=%0d dv=%0d fe=%0d expected 0", rx_cnt, dv_cnt, fe_cnt);
        end
    endtask

    task automatic test_arrow_make_break();
        int rx0;
        rx0 = rx_cnt;
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++;
        if (rx_cnt - rx0 != 2) begin
            errors++;
            $display("FAIL arrow_rx_count: got %0d expected 2", rx_cnt - rx0);
        end
        check_state("arrow_make");
        checks++;
        if (bus.dir !== 2'd2 || bus.held !== 4'b0100) begin
            errors++;
            $display("FAIL arrow_make_abs: dir=%0d held=%b expected 2/0100", bus.dir, bus.held);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check_state("arrow_break");
    endtask

    task automatic test_parity_error();
        int rx0, fe0;
        rx0 = rx_cnt; fe0 = fe_cnt;
        send_frame(8'h6B, 1'b1);
        model_err();
        @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1 || rx_cnt != rx0) begin
            errors++;
            $display("FAIL parity_err: frame_err=%0d rx=%0d expected 1/0", fe_cnt - fe0, rx_cnt - rx0);
        end
        send_byte(8'hE0);
        send_byte(8'h6B);
        check_state("after_parity");
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'hE0);
        send_bits(11'b000_1010_1100, 6);
        ps2_dat = 1'b1;
        repeat (2 * TIMEOUT) @(posedge clk);
        model_err();
        @(negedge clk);
        checks++;
        if (fe_cnt - fe0 != 1 || bus.frame_state !== FR_IDLE) begin
            errors++;
            $display("FAIL timeout: frame_err=%0d state=%0d expected 1/IDLE", fe_cnt - fe0, bus.frame_state);
        end
        checks++;
        if (bus.dec_state !== DEC_IDLE) begin
            errors++;
            $display("FAIL timeout_prefix_clear: dec_state=%0d expected IDLE", bus.dec_state);
        end
        send_byte(8'hE0);
        send_byte(8'h72);
        check_state("after_timeout");
    endtask

    task automatic test_glitch();
        int rx0, fe0;
        rx0 = rx_cnt; fe0 = fe_cnt;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (fe_cnt != fe0 || rx_cnt != rx0 || bus.frame_state !== FR_IDLE) begin
            errors++;
            $display("FAIL glitch: frame_err=%0d rx=%0d state=%0d expected 0/0/IDLE",
                     fe_cnt - fe0, rx_cnt - rx0, bus.frame_state);
        end
        send_byte(8'hE0);
        send_byte(8'h74);
        check_state("after_glitch");
    endtask

    task automatic test_reset_mid_frame();
        send_bits({3'b111, 8'hE0}, 4);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        reset = 1'b0;
        ps2_dat = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.dir !== 2'd1 || bus.held !== 4'b0 || bus.rx_byte !== 8'h00 ||
            bus.frame_state !== FR_IDLE) begin
            errors++;
            $display("FAIL reset_mid: dir=%0d held=%b rx_byte=%02h state=%0d expected 1/0000/00/IDLE",
                     bus.dir, bus.held, bus.rx_byte, bus.frame_state);
        end
        repeat (4 * HP) @(posedge clk);
`ifdef PS2_WASD_EN
        send_byte(8'h1D);
`else
        send_byte(8'h74);
`endif
        check_state("reset_mid_no_prefix");
    endtask

    task automatic test_random();
        logic [7:0] pool [10];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C, 8'h23, 8'h1D, 8'h1B};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) begin
                send_frame(b, 1'b1);
                model_err();
            end else begin
                send_byte(b);
            end
            check_state("random");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rx_missing: %0d expected bytes never received", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_arrow_make_break();
        test_parity_error();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
